// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide data memory.
// Sub-word stores are done as read-modify-write; faults never touch memory.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  fault_o,
  output logic                  Mem_Write_o,
  output logic                  Mem_Read_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic                  legal_c;
  logic                  aligned_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] merge_c;

  // Request legality and alignment, evaluated on the live request inputs.
  always_comb begin
    legal_c   = 1'b0;
    aligned_c = 1'b0;
    case (funct3_i)
      3'b000:         begin legal_c = 1'b1;  aligned_c = 1'b1;                  end
      3'b001:         begin legal_c = 1'b1;  aligned_c = ~addr_i[0];            end
      3'b010:         begin legal_c = 1'b1;  aligned_c = (addr_i[1:0] == 2'b00); end
      3'b100, 3'b101: begin legal_c = ~we_i; aligned_c = ~(funct3_i[0] & addr_i[0]); end
      default:        begin legal_c = 1'b0;  aligned_c = 1'b1;                  end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    byte_c = 8'(Read_Data_i >> {lane_q, 3'b000});
    half_c = 16'(Read_Data_i >> {lane_q[1], 4'b0000});
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = Read_Data_i;
    endcase
  end

  // Substitute the store byte/half into the word read back from memory.
  always_comb begin
    merge_c = Read_Data_i;
    if (f3_q[0]) begin
      if (lane_q[1]) merge_c[31:16] = wdata_q;
      else           merge_c[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Control FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      f3_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fault_o      <= 1'b0;
      rdata_o      <= '0;
      Mem_Write_o  <= 1'b0;
      Mem_Read_o   <= 1'b0;
      Address_o    <= '0;
      Write_Data_o <= '0;
    end else begin
      done_o  <= 1'b0;
      fault_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            f3_q    <= funct3_i;
            lane_q  <= addr_i[1:0];
            wdata_q <= wdata_i[15:0];
            busy_o  <= 1'b1;
            if (!(legal_c && aligned_c)) begin
              state   <= DONE;
              done_o  <= 1'b1;
              fault_o <= 1'b1;
            end else if (!we_i) begin
              state      <= LOAD;
              Mem_Read_o <= 1'b1;
              Address_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            end else if (funct3_i == 3'b010) begin
              state        <= WRITE;
              Mem_Write_o  <= 1'b1;
              Address_o    <= {addr_i[DATA_WIDTH-1:2], 2'b00};
              Write_Data_o <= wdata_i;
            end else begin
              state      <= RMW_RD;
              Mem_Read_o <= 1'b1;
              Address_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            end
          end
        end
        LOAD: begin
          state      <= DONE;
          rdata_o    <= load_c;
          Mem_Read_o <= 1'b0;
          Address_o  <= '0;
          done_o     <= 1'b1;
        end
        RMW_RD: begin
          state        <= WRITE;
          Mem_Read_o   <= 1'b0;
          Mem_Write_o  <= 1'b1;
          Write_Data_o <= merge_c;
        end
        WRITE: begin
          state        <= DONE;
          Mem_Write_o  <= 1'b0;
          Write_Data_o <= '0;
          Address_o    <= '0;
          done_o       <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy_o       <= 1'b0;
          Mem_Read_o   <= 1'b0;
          Mem_Write_o  <= 1'b0;
          Address_o    <= '0;
          Write_Data_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data-memory interface (Mem_Write / Mem_Read / Address / Write_Data / Read_Data) for the RISC-V core.
- Accepts one load/store request from the core and performs the byte, halfword and word accesses of RV32I (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Sign/zero-extends load data.
- Performs sub-word stores as read-modify-write, because data memory only accepts whole-word writes.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- DATA_WIDTH, 32, width of data and address buses. Only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  1  request strobe. Sampled only in IDLE.
- we_i  input  1  1 = store, 0 = load.
- funct3_i  input  3  RV32I funct3 of the load/store instruction.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data. Low byte/half is used for SB/SH.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  extended load result. Valid while done_o=1, held until the next load completes.
- fault_o  output  1  valid with done_o: misaligned or illegal funct3.
- Mem_Write_o  output  1  memory write strobe. Memory writes on the posedge while high.
- Mem_Read_o  output  1  memory read enable.
- Address_o  output  32  word-aligned byte address {addr[31:2],2'b00}. 0 in IDLE/DONE.
- Write_Data_o  output  32  word to write. 0 when Mem_Write_o=0.
- Read_Data_i  input  32  combinational read data for the current Address_o (masked to 0 by memory when Mem_Read_o=0).

Behaviour:
- Reset (async):
  - state=IDLE; all latched request registers, merge register and rdata_o = 0.
  - done_o = fault_o = Mem_Write_o = Mem_Read_o = 0; Address_o = Write_Data_o = 0.
  - Asserting reset mid-operation drops strobes immediately. No write is issued and no done_o is produced.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE, on req_i=1:
  - Latch we, funct3, addr, wdata.
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Alignment: word requires addr[1:0]=00; half requires addr[0]=0.
  - Fault (illegal or misaligned) -> DONE with fault latched, no memory strobe.
  - Else load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
- LOAD: Mem_Read_o=1. At the clock edge, extract the lane selected by addr[1:0] (little-endian: byte k = bits 8k+7:8k), extend it into rdata_o, then -> DONE.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RMW_RD: Mem_Read_o=1. Capture Read_Data_i into the merge register, then -> WRITE.
- WRITE: Mem_Write_o=1.
  - Write_Data_o = wdata for SW.
  - For SB/SH: merge register with byte/half of wdata substituted at lane addr[1:0]; other lanes unchanged.
  - -> DONE.
- DONE: done_o=1 for exactly one cycle, fault_o=fault; -> IDLE. fault_o is 0 outside DONE.
- req_i is ignored whenever state != IDLE. A req_i held high in the DONE cycle is accepted at the following IDLE cycle.
- Latency, counted from the req_i-sampling edge to the edge that asserts done_o:
  - load: 2 cycles; SW: 2; SB/SH: 3; fault: 1.
- At most one Mem_Write_o cycle per store, and never on a fault.
- Mem_Read_o and Mem_Write_o are never high in the same cycle.
- Store does not modify rdata_o.

Test Plan:
- Preload word 0x10010004=0x8899AABB. LB @0x10010005 -> done_o at +2 cycles, rdata_o=0xFFFFFFAA, fault_o=0. LBU same address -> 0x000000AA.
- Same preload. LH @0x10010006 -> 0xFFFF8899. LHU -> 0x00008899. LW @0x10010004 -> 0x8899AABB. Address_o=0x10010004 during LOAD.
- SB wdata=0x12345677 @0x10010006 -> one read cycle, then one write cycle with Write_Data_o=0x8877AABB; done_o at +3; memory word = 0x8877AABB. SW 0xDEADBEEF @0x10010008 -> single write cycle, done at +2.
- LW @0x10010002, SH @0x10010001, load funct3=011 -> done_o and fault_o at +1; Mem_Read_o and Mem_Write_o stay 0 throughout; memory unchanged.
- Assert reset during RMW_RD of an SB -> strobes drop the same cycle, no Mem_Write_o pulse, no done_o, outputs 0; after release a new LW completes normally.
- Hold req_i=1 continuously with LW requests -> back-to-back completions every 3 cycles (req sample, LOAD, DONE); busy_o low exactly one cycle between them.
